// File: rtl/alu_result_tx.sv
// Serial framer for an 8-bit ALU result plus its Z/N/C/V flags: idle-high line, LSB first, start/stop framed.
// Optional feature macro ALU_TX_PARITY_EN appends an even-parity bit after the flags (15-bit frame instead of 14).
module alu_result_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] result,
    input  logic       zero,
    input  logic       negative,
    input  logic       carry,
    input  logic       overflow,
    input  logic       load,
    output logic       ready,
    output logic       tx_out,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_FLAGS,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [7:0] BAUD_LAST   = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] BAUD_PENULT = 8'(CLKS_PER_BIT - 2);

    state_t      r_state;
    logic [7:0]  r_baud;
    logic [2:0]  r_bit;
    logic [11:0] r_shift;
    logic        r_ready;
    logic        r_busy;
    logic        r_tx;
    logic        r_done;
`ifdef ALU_TX_PARITY_EN
    logic        r_parity;
`endif

    logic w_baud_wrap;
    assign w_baud_wrap = (r_baud == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
`ifdef ALU_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (load) begin
                    r_shift <= {overflow, carry, negative, zero, result};
`ifdef ALU_TX_PARITY_EN
                    r_parity <= ^{overflow, carry, negative, zero, result};
`endif
                    r_baud  <= '0;
                    r_bit   <= '0;
                    r_tx    <= 1'b0;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b1;
                    r_state <= S_START;
                end
            end else if (!w_baud_wrap) begin
                r_baud <= r_baud + 8'd1;
                // frame_done is registered, so it is raised one edge ahead of the stop bit's last cycle.
                if (r_state == S_STOP) r_done <= (r_baud == BAUD_PENULT);
            end else begin
                r_baud <= '0;
                case (r_state)
                    S_START: begin
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_state <= S_DATA;
                    end
                    S_DATA: begin
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        if (r_bit == 3'd7) begin
                            r_bit   <= '0;
                            r_state <= S_FLAGS;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end
                    S_FLAGS: begin
                        if (r_bit == 3'd3) begin
                            r_bit <= '0;
`ifdef ALU_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= S_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                            r_done  <= (BAUD_LAST == 8'd0);
`endif
                        end else begin
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                            r_bit   <= r_bit + 3'd1;
                        end
                    end
                    S_PARITY: begin
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                        r_done  <= (BAUD_LAST == 8'd0);
                    end
                    S_STOP: begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign ready      = r_ready;
    assign busy       = r_busy;
    assign tx_out     = r_tx;
    assign frame_done = r_done;

endmodule

// File: doc/alu_result_tx.md
# alu_result_tx

Serial transmitter for ALU results. Captures one 8-bit ALU result and its four status flags (Zero, Negative, Carry, Overflow) on a valid/ready handshake. Shifts them out LSB-first on a single idle-high output pin as a framed bit stream, so an off-chip receiver can read both the result and the flags, which have no pins in the parallel output path. Sits between the ALU outputs and one spare bidirectional pin of the top-level wrapper.

## Interface
- CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range 1..255.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- result  input  8  ALU result to transmit.
- zero, negative, carry, overflow  input  1 each  ALU flags, captured together with result.
- load  input  1  request to transmit; qualified by ready.
- ready  output  1  high when a new load is accepted this cycle.
- tx_out  output  1  serial line; idle high.
- busy  output  1  high while a frame is on the line.
- frame_done  output  1  one-cycle pulse on the last cycle of the stop bit.

## Operation
- Reset values: tx_out=1, ready=1, busy=0, frame_done=0; state IDLE; counters 0.
- Accept: load && ready at a rising edge latches {overflow,carry,negative,zero,result} into a 12-bit shift register. State goes to START.
- load while ready=0 is ignored; no queueing.
- Frame order: start bit (0), result[0..7], zero, negative, carry, overflow, [parity], stop bit (1).
- States: IDLE -> START -> DATA (8 bits) -> FLAGS (4 bits) -> [PARITY] -> STOP -> IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1. The state or bit advances when the counter wraps.
- Bit counter: 0..7 in DATA, 0..3 in FLAGS. Its wrap triggers the next state.
- ready = (state==IDLE); busy = !ready; tx_out is registered.
- Inputs result and flags are don't-care except in the accept cycle. Changes mid-frame have no effect.

## Timing
- Accept at edge N: tx_out=0 and busy=1 from edge N+1.
- Each bit holds exactly CLKS_PER_BIT cycles.
- Frame length: 14 bits without parity, 15 bits with parity.
- frame_done is high during the final cycle of the stop bit. ready rises at the following edge, with tx_out remaining 1.
- Back-to-back: a load in the first ready cycle starts the next start bit immediately. The stop bit is never shortened.
- CLKS_PER_BIT=1: one bit per cycle, with no idle gap beyond the required ready cycle.
- rst asserted mid-frame: at the next edge tx_out=1, ready=1, busy=0, and frame_done=0. The partial frame is abandoned and no completion pulse is produced.
- rst and load in the same cycle: rst wins and the load is dropped.

## Configuration
- ALU_TX_PARITY_EN defined: a PARITY state is inserted after FLAGS. It sends an even-parity bit over the 12 payload bits, so total ones including parity is even. Frame is 15 bits.
- Undefined: no PARITY state; FLAGS goes directly to STOP. Frame is 14 bits.

## Test plan
- Reset: hold rst 2 cycles with load=1 -> tx_out=1, ready=1, busy=0, frame_done=0, and no frame starts.
- Basic frame, CLKS_PER_BIT=4, macro off: result=0xA5, Z=0 N=1 C=0 V=1.
  - Line sequence per bit is 0, 1,0,1,0,0,1,0,1, 0,1,0,1, 1.
  - Each bit lasts 4 cycles, for 56 cycles total.
  - frame_done pulses at cycle 56; ready returns at cycle 57.
- Parity, macro on: result=0xA5 with the same flags -> parity bit 0 (six ones), 15 bits. result=0x01, all flags 0 -> parity bit 1.
- Busy ignore: a second load with result=0xFF mid-frame -> the first frame completes unchanged and no second frame starts.
- Back-to-back, CLKS_PER_BIT=1: load held high with 0x00 then 0xFF -> two contiguous 14-cycle frames separated by exactly one ready cycle with tx_out=1.
- Reset mid-frame: assert rst during DATA bit 3 -> tx_out=1 and ready=1 on the next edge, no frame_done. A new load of 0x3C then transmits a complete, correct frame.
